// File: rtl/run_monitor_pkg.sv
// Shared opcode constant and state encodings for the CPU run monitor.
package run_monitor_pkg;

  localparam logic [7:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    RESET_CPUS,
    RUN,
    REPORT
  } top_state_e;

  typedef enum logic [1:0] {
    ARMED,
    ACTIVE,
    HALTED,
    TIMED_OUT
  } trk_state_e;

endpackage

// File: rtl/run_channel_tracker.sv
// Per-CPU tracker: waits for the program to start, detects a NOP-run halt,
// and latches the terminal-state comparison or a watchdog timeout.
module run_channel_tracker
  import run_monitor_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SP_WIDTH    = 16,
  parameter int HALT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run_en,
  input  logic                  timeout_hit,
  input  logic [7:0]            op_code,
  input  logic [SP_WIDTH-1:0]   top_of_stack,
  input  logic [DATA_WIDTH-1:0] stack_word,
  input  logic [SP_WIDTH-1:0]   exp_tos,
  input  logic [DATA_WIDTH-1:0] exp_word,
  input  logic                  check_word,
  output logic                  resolved,
  output logic                  chan_pass,
  output logic                  chan_timeout
);

  localparam int HW = $clog2(HALT_CYCLES + 1);

  trk_state_e    state;
  logic [HW-1:0] halt_cnt;
  logic          is_nop;
  logic          halt_now;
  logic          match;

  assign is_nop   = (op_code == NOP);
  assign halt_now = (state == ACTIVE) && is_nop && (halt_cnt == HW'(HALT_CYCLES - 1));
  assign match    = (top_of_stack == exp_tos) && (!check_word || (stack_word == exp_word));
  assign resolved = (state == HALTED) || (state == TIMED_OUT);

  // A halt in the same cycle as the watchdog wins, so the halt check comes first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARMED;
      halt_cnt     <= '0;
      chan_pass    <= 1'b0;
      chan_timeout <= 1'b0;
    end else if (clear) begin
      state        <= ARMED;
      halt_cnt     <= '0;
      chan_pass    <= 1'b0;
      chan_timeout <= 1'b0;
    end else if (run_en) begin
      case (state)
        ARMED: begin
          if (timeout_hit) begin
            state        <= TIMED_OUT;
            chan_timeout <= 1'b1;
            chan_pass    <= 1'b0;
          end else if (!is_nop) begin
            state    <= ACTIVE;
            halt_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (halt_now) begin
            state     <= HALTED;
            chan_pass <= match;
          end else if (timeout_hit) begin
            state        <= TIMED_OUT;
            chan_timeout <= 1'b1;
            chan_pass    <= 1'b0;
          end else if (is_nop) begin
            halt_cnt <= halt_cnt + HW'(1);
          end else begin
            halt_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Supervisor that resets a CPU bank, watches every instance run to a halt or
// watchdog timeout, and reports per-channel and aggregate pass/fail.
module cpu_run_monitor
  import run_monitor_pkg::*;
#(
  parameter int CHANNELS    = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int SP_WIDTH    = 16,
  parameter int TIMEOUT     = 1024,
  parameter int HALT_CYCLES = 4,
  parameter int RST_CYCLES  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CHANNELS*8-1:0]            op_code,
  input  logic [CHANNELS*SP_WIDTH-1:0]     top_of_stack,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   stack_word,
  input  logic [CHANNELS*SP_WIDTH-1:0]     exp_tos,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   exp_word,
  input  logic [CHANNELS-1:0]              check_word,
  output logic                             cpu_rst,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [CHANNELS-1:0]              chan_pass,
  output logic [CHANNELS-1:0]              chan_timeout,
  output logic [$clog2(TIMEOUT+1)-1:0]     cycle_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  top_state_e          state;
  logic [RW-1:0]       rst_cnt;
  logic                start_ok;
  logic                run_en;
  logic                timeout_hit;
  logic [CHANNELS-1:0] resolved;

  assign start_ok = start && ((state == IDLE) || (state == REPORT));
  assign run_en   = (state == RUN);
  // Fires on the cycle whose increment brings cycle_count to TIMEOUT.
  assign timeout_hit = run_en && (cycle_count >= CW'(TIMEOUT - 1));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_trk
    run_channel_tracker #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SP_WIDTH    (SP_WIDTH),
      .HALT_CYCLES (HALT_CYCLES)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .clear        (start_ok),
      .run_en       (run_en),
      .timeout_hit  (timeout_hit),
      .op_code      (op_code[g*8 +: 8]),
      .top_of_stack (top_of_stack[g*SP_WIDTH +: SP_WIDTH]),
      .stack_word   (stack_word[g*DATA_WIDTH +: DATA_WIDTH]),
      .exp_tos      (exp_tos[g*SP_WIDTH +: SP_WIDTH]),
      .exp_word     (exp_word[g*DATA_WIDTH +: DATA_WIDTH]),
      .check_word   (check_word[g]),
      .resolved     (resolved[g]),
      .chan_pass    (chan_pass[g]),
      .chan_timeout (chan_timeout[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      cpu_rst     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, REPORT: begin
          if (start) begin
            state       <= RESET_CPUS;
            rst_cnt     <= '0;
            cpu_rst     <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            cycle_count <= '0;
          end
        end
        RESET_CPUS: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        RUN: begin
          if (cycle_count != CW'(TIMEOUT)) cycle_count <= cycle_count + CW'(1);
          if (&resolved) begin
            state <= REPORT;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= &chan_pass;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor with two stubbed CPUs driven from
// per-channel program descriptions.
module tb_cpu_run_monitor;

  localparam int CH = 2;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int TO = 64;
  localparam int HC = 4;
  localparam int RC = 2;
  localparam int CW = $clog2(TO + 1);

  logic              clk;
  logic              rst;
  logic              start;
  logic [CH*8-1:0]   op_code;
  logic [CH*SW-1:0]  top_of_stack;
  logic [CH*DW-1:0]  stack_word;
  logic [CH*SW-1:0]  exp_tos;
  logic [CH*DW-1:0]  exp_word;
  logic [CH-1:0]     check_word;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CH-1:0]     chan_pass;
  logic [CH-1:0]     chan_timeout;
  logic [CW-1:0]     cycle_count;

  cpu_run_monitor #(
    .CHANNELS    (CH),
    .DATA_WIDTH  (DW),
    .SP_WIDTH    (SW),
    .TIMEOUT     (TO),
    .HALT_CYCLES (HC),
    .RST_CYCLES  (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_code      (op_code),
    .top_of_stack (top_of_stack),
    .stack_word   (stack_word),
    .exp_tos      (exp_tos),
    .exp_word     (exp_word),
    .check_word   (check_word),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .chan_pass    (chan_pass),
    .chan_timeout (chan_timeout),
    .cycle_count  (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CPU stubs: program described by leading NOPs, active length, an optional
  // 3-NOP gap, or an endless alternating pattern; terminal state appears once
  // the active section is over.
  int             lead [CH];
  int             len  [CH];
  int             gap  [CH];
  bit             never[CH];
  logic [SW-1:0]  ftos [CH];
  logic [DW-1:0]  fword[CH];
  int             tb_k;

  always @(posedge clk) tb_k <= cpu_rst ? 0 : tb_k + 1;

  always_comb begin
    op_code      = '0;
    top_of_stack = '0;
    stack_word   = '0;
    for (int c = 0; c < CH; c++) begin
      if (never[c])
        op_code[c*8 +: 8] = (tb_k % 2 == 0) ? 8'h10 : 8'h00;
      else if (tb_k < lead[c])
        op_code[c*8 +: 8] = 8'h00;
      else if (tb_k < lead[c] + len[c])
        op_code[c*8 +: 8] = (gap[c] >= 0 && tb_k >= gap[c] && tb_k < gap[c] + 3) ? 8'h00 : 8'h21;
      else
        op_code[c*8 +: 8] = 8'h00;
      if (!never[c] && tb_k >= lead[c] + len[c]) begin
        top_of_stack[c*SW +: SW] = ftos[c];
        stack_word[c*DW +: DW]   = fword[c];
      end
    end
  end

  typedef struct {
    string         name;
    logic          pass;
    logic [CH-1:0] cp;
    logic [CH-1:0] ct;
    logic [CW-1:0] cc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_q;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every rising edge of done consumes one expected report.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, ".pass"},         pass,         mon_e.pass);
        check({mon_e.name, ".chan_pass"},    chan_pass,    mon_e.cp);
        check({mon_e.name, ".chan_timeout"}, chan_timeout, mon_e.ct);
        check({mon_e.name, ".cycle_count"},  cycle_count,  mon_e.cc);
      end
    end
    done_q <= done;
  end

  task automatic set_ch(input int c, input int ld, input int ln, input int gp, input bit nv,
                        input logic [SW-1:0] t, input logic [DW-1:0] w,
                        input logic [SW-1:0] et, input logic [DW-1:0] ew, input bit chk);
    lead[c]  = ld;
    len[c]   = ln;
    gap[c]   = gp;
    never[c] = nv;
    ftos[c]  = t;
    fword[c] = w;
    exp_tos[c*SW +: SW]  = et;
    exp_word[c*DW +: DW] = ew;
    check_word[c]        = chk;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({nm, ".done_seen"}, done, 1);
  endtask

  task automatic run_test(input string nm, input logic p, input logic [CH-1:0] cp,
                          input logic [CH-1:0] ct, input int cc, input bit poke, input bit to_chk);
    exp_t e;
    int   cnt = 0;
    int   g   = 0;
    e.name = nm;
    e.pass = p;
    e.cp   = cp;
    e.ct   = ct;
    e.cc   = CW'(cc);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, ".done_clr"}, done, 0);
    check({nm, ".busy"}, busy, 1);
    while (cpu_rst && g < 20) begin
      cnt++;
      g++;
      if (poke) start = 1'b1;
      @(negedge clk);
    end
    check({nm, ".rst_len"}, cnt, RC);
    check({nm, ".cc0"}, cycle_count, 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b0;
      check({nm, ".no_rerst"}, {cpu_rst, busy}, 2'b01);
    end
    if (to_chk) begin
      g = 0;
      while (cycle_count != CW'(TO) && g < 200) begin
        @(negedge clk);
        g++;
      end
      check({nm, ".to_at_limit"}, {done, chan_timeout}, {1'b0, ct});
    end
    wait_done(nm, 300);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst   = 1'b1;
    start = 1'b0;
    set_ch(0, 0, 10, -1, 0, 16'h2, 32'hffff_cafe, 16'h2, 32'hffff_cafe, 1);
    set_ch(1, 0, 6, -1, 0, 16'h5, 32'h0000_1111, 16'h5, 32'h0000_1111, 1);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.outputs", {cpu_rst, busy, done, pass, chan_pass, chan_timeout, cycle_count}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle.outputs", {cpu_rst, busy, done}, 0);

    // Both channels halt cleanly; start is held high during the reset pulse and early RUN.
    run_test("t1_pass", 1'b1, 2'b11, 2'b00, 15, 1, 0);

    // Back-to-back: ch1 terminal tos mismatch.
    set_ch(1, 0, 6, -1, 0, 16'h1, 32'h0000_1111, 16'h0, 32'h0000_1111, 1);
    run_test("t2_tos", 1'b0, 2'b01, 2'b00, 15, 0, 0);

    // ch0 word mismatch with check enabled fails; ch1 word mismatch with check disabled passes.
    set_ch(0, 0, 10, -1, 0, 16'h2, 32'hffff_cafe, 16'h2, 32'hffff_cafd, 1);
    set_ch(1, 0, 6, -1, 0, 16'h5, 32'h0000_1234, 16'h5, 32'h0000_5678, 0);
    run_test("t3_word", 1'b0, 2'b10, 2'b00, 15, 0, 0);

    // ch0 never halts: watchdog at cycle_count == TIMEOUT.
    set_ch(0, 0, 0, -1, 1, 16'h2, 32'h0, 16'h2, 32'h0, 0);
    set_ch(1, 0, 5, -1, 0, 16'h3, 32'h0, 16'h3, 32'h0, 0);
    run_test("t4_timeout", 1'b0, 2'b10, 2'b01, TO, 0, 1);

    // Leading NOPs and a 3-NOP gap must not look like a halt.
    set_ch(0, 3, 12, 6, 0, 16'h7, 32'hdead_beef, 16'h7, 32'hdead_beef, 1);
    set_ch(1, 5, 4, -1, 0, 16'h9, 32'h0000_0009, 16'h9, 32'h0000_0009, 1);
    run_test("t5_gaps", 1'b1, 2'b11, 2'b00, 20, 0, 0);

    // Abort mid-run with asynchronous reset.
    set_ch(0, 0, 10, -1, 0, 16'h2, 32'hffff_cafe, 16'h2, 32'hffff_cafe, 1);
    set_ch(1, 0, 2, -1, 0, 16'h5, 32'h0000_1111, 16'h5, 32'h0000_1111, 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (cpu_rst && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
    check("abort.pre", {busy, chan_pass, cycle_count}, {1'b1, 2'b10, CW'(8)});
    #2 rst = 1'b0;
    #1 check("abort.outputs", {cpu_rst, busy, done, pass, chan_pass, chan_timeout, cycle_count}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort.idle", {cpu_rst, busy, done}, 0);

    // Fresh run after the abort is unaffected by earlier results.
    set_ch(1, 0, 6, -1, 0, 16'h5, 32'h0000_1111, 16'h5, 32'h0000_1111, 1);
    run_test("t7_after_abort", 1'b1, 2'b11, 2'b00, 15, 0, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
